// File: rtl/lane_merge_pkg.sv
// Shared types and constants for the lane_merge block: FSM states, lane count,
// pixel width and a population-count helper used for drop accounting.
package lane_merge_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = $clog2(NUM_LANES);
  localparam int unsigned PIX_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [LANE_W:0] count_ones(input logic [NUM_LANES-1:0] v);
    count_ones = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      count_ones = count_ones + {{LANE_W{1'b0}}, v[i]};
    end
  endfunction

endpackage

// File: rtl/lane_merge_if.sv
// Merged output stream of lane_merge: registered pixel with valid/ready handshake.
interface lane_merge_if;
  import lane_merge_pkg::*;

  logic [PIX_W-1:0] m_pixel;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_pixel, output m_valid, input m_ready);
  modport slave  (input m_pixel, input m_valid, output m_ready);

endinterface

// File: rtl/lane_merge_lane_fifo.sv
// lane_fifo: synchronous FIFO with extra-bit wrap pointers and a synchronous flush.
// Read data is the combinational head entry; pop/push on an empty/full FIFO is
// the caller's responsibility to gate.
module lane_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/lane_merge.sv
// lane_merge: merges four filter-lane pixel streams into one raster-order stream
// by strict round robin. Optional macro LANE_MERGE_OVF_CNT_EN adds ovf_cnt[7:0].
module lane_merge
  import lane_merge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FRAME_PIXELS = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] in_pixel0,
  input  logic [PIX_W-1:0] in_pixel1,
  input  logic [PIX_W-1:0] in_pixel2,
  input  logic [PIX_W-1:0] in_pixel3,
  input  logic             in_valid0,
  input  logic             in_valid1,
  input  logic             in_valid2,
  input  logic             in_valid3,
  lane_merge_if.master     m_if,
  output logic [16:0]      pix_cnt,
  output logic             busy,
  output logic             done,
  output logic             ovf
`ifdef LANE_MERGE_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_cnt
`endif
);

  localparam logic [16:0] LAST_PIX = 17'(FRAME_PIXELS - 1);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                m_valid_q, m_valid_d;
  logic [PIX_W-1:0]    m_pixel_q, m_pixel_d;
  logic [16:0]         pix_cnt_q, pix_cnt_d;
  logic                ovf_q, ovf_d;

  logic [PIX_W-1:0]     lane_pix  [NUM_LANES];
  logic [PIX_W-1:0]     fifo_dout [NUM_LANES];
  logic [NUM_LANES-1:0] lane_vld;
  logic [NUM_LANES-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic                 run, hs, last_hs, pop_go;

  assign lane_pix[0] = in_pixel0;
  assign lane_pix[1] = in_pixel1;
  assign lane_pix[2] = in_pixel2;
  assign lane_pix[3] = in_pixel3;
  assign lane_vld    = {in_valid3, in_valid2, in_valid1, in_valid0};

  assign run     = (state_q == RUN);
  assign hs      = m_valid_q && m_if.m_ready;
  assign last_hs = hs && (pix_cnt_q == LAST_PIX);
  // No refill on the final handshake so the frame closes with m_valid low.
  assign pop_go  = run && !start && !last_hs && !fifo_empty[lane_q] &&
                   (!m_valid_q || m_if.m_ready);

  always_comb begin
    fifo_pop  = '0;
    fifo_push = '0;
    drop      = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      fifo_pop[i]  = pop_go && (lane_q == LANE_W'(i));
      // A full FIFO still takes the write when its head leaves in the same cycle.
      fifo_push[i] = run && !start && lane_vld[i] && (!fifo_full[i] || fifo_pop[i]);
      drop[i]      = run && !start && lane_vld[i] && fifo_full[i] && !fifo_pop[i];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIX_W)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (start),
      .push  (fifo_push[g]),
      .pop   (fifo_pop[g]),
      .din   (lane_pix[g]),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    m_valid_d = m_valid_q;
    m_pixel_d = m_pixel_q;
    pix_cnt_d = pix_cnt_q;
    ovf_d     = ovf_q;
    if (start) begin
      state_d   = RUN;
      lane_d    = '0;
      m_valid_d = 1'b0;
      pix_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (hs) begin
            pix_cnt_d = pix_cnt_q + 17'd1;
            m_valid_d = 1'b0;
          end
          if (last_hs) begin
            state_d = DONE;
          end
          if (pop_go) begin
            m_valid_d = 1'b1;
            m_pixel_d = fifo_dout[lane_q];
            lane_d    = lane_q + LANE_W'(1);
          end
          if (|drop) begin
            ovf_d = 1'b1;
          end
        end
        DONE:    m_valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      m_valid_q <= 1'b0;
      m_pixel_q <= '0;
      pix_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      m_valid_q <= m_valid_d;
      m_pixel_q <= m_pixel_d;
      pix_cnt_q <= pix_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_if.m_valid = m_valid_q;
  assign m_if.m_pixel = m_pixel_q;
  assign pix_cnt      = pix_cnt_q;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign ovf          = ovf_q;

`ifdef LANE_MERGE_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic [8:0] ovf_sum;

  always_comb begin
    ovf_sum = {1'b0, ovf_cnt_q} + 9'(count_ones(drop));
    if (start) begin
      ovf_cnt_d = '0;
    end else if (ovf_sum > 9'd255) begin
      ovf_cnt_d = '1;
    end else begin
      ovf_cnt_d = ovf_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
